// File: rtl/uart_host_pkg.sv
// Shared types and constants for the host-side UART transmitter.
// Optional even parity is selected with UART_HOST_TX_PARITY_EN.
package uart_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_e;

    localparam int   UartDataBits  = 8;
    localparam logic UartIdleLevel = 1'b1;

endpackage

// File: rtl/uart_host_fifo.sv
// Small synchronous byte FIFO feeding the UART transmitter.
// Read data is presented combinationally from the head entry.
module uart_host_fifo #(
    parameter int Depth = 4,
    parameter int Width = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   level
);

    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem [Depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (AW+1)'(Depth));
    assign empty = (count == '0);
    assign level = count;
    assign rdata = mem[rd_ptr];

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_host_tx.sv
// Host-side UART transmitter: FIFO-buffered bytes sent 8N1, LSB first.
// Define UART_HOST_TX_PARITY_EN for 8E1 framing with an even parity bit.
module uart_host_tx
    import uart_host_pkg::*;
#(
    parameter int ClksPerBit = 68,
    parameter int FifoDepth  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [7:0]                   data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic                         tx_o,
    output logic                         busy_o,
    output logic [$clog2(FifoDepth):0]   level_o
);

    localparam int TW = $clog2(ClksPerBit);
    localparam logic [TW-1:0] TLast = TW'(ClksPerBit - 1);

    uart_tx_state_e          state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [2:0]              idx_q, idx_d;
    logic [UartDataBits-1:0] shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    load;
    logic                    bit_end;
    logic [7:0]              fifo_rdata;
    logic                    fifo_full;
    logic                    fifo_empty;
`ifdef UART_HOST_TX_PARITY_EN
    logic                    par_q, par_d;
`endif

    uart_host_fifo #(
        .Depth (FifoDepth),
        .Width (8)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (valid_i),
        .wdata (data_i),
        .pop   (load),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level_o)
    );

    assign bit_end = (timer_q == TLast);
    assign ready_o = !fifo_full;
    assign busy_o  = (state_q != ST_IDLE) || !fifo_empty;
    assign tx_o    = tx_q;

    always_comb begin
        state_d = state_q;
        timer_d = bit_end ? '0 : timer_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        load    = 1'b0;
`ifdef UART_HOST_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                load    = !fifo_empty;
            end
            ST_START: begin
                if (bit_end) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'(UartDataBits - 1)) begin
`ifdef UART_HOST_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = {1'b0, shift_q[UartDataBits-1:1]};
                    end
                end
            end
`ifdef UART_HOST_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    state_d = ST_IDLE;
                    load    = !fifo_empty;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Popping a byte always starts a fresh frame with no idle gap.
        if (load) begin
            state_d = ST_START;
            shift_d = fifo_rdata;
            idx_d   = '0;
            timer_d = '0;
`ifdef UART_HOST_TX_PARITY_EN
            par_d   = ^fifo_rdata;
`endif
        end

        unique case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_HOST_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = UartIdleLevel;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= UartIdleLevel;
`ifdef UART_HOST_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_HOST_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_host_tx.sv
// Self-checking bench for uart_host_tx against a frame-level reference model.
// Honours UART_HOST_TX_PARITY_EN to select 8E1 framing expectations.
`timescale 1ns/1ps
module tb_uart_host_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef UART_HOST_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FLEN = FB * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    data = '0;
    logic          valid = 1'b0;
    logic          ready, tx, busy;
    logic [LW-1:0] level;

    logic [7:0]    lb_data = '0;
    logic          lb_valid = 1'b0;
    logic          lb_ready, lb_tx, lb_busy;
    logic [LW-1:0] lb_level;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_host_tx #(.ClksPerBit(CPB), .FifoDepth(DEPTH)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (data),
        .valid_i (valid),
        .ready_o (ready),
        .tx_o    (tx),
        .busy_o  (busy),
        .level_o (level)
    );

    uart_host_tx #(.ClksPerBit(68), .FifoDepth(DEPTH)) u_lb (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (lb_data),
        .valid_i (lb_valid),
        .ready_o (lb_ready),
        .tx_o    (lb_tx),
        .busy_o  (lb_busy),
        .level_o (lb_level)
    );

    // Line level expected in bit slot k of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_HOST_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle tx=%b busy=%b exp tx=1 busy=0", tx, busy);
        end
    endtask

    task automatic test_single;
        int errs = 0;
        @(negedge clk);
        data = 8'hA5; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        total++;
        if (tx !== 1'b1 || level !== LW'(1)) begin
            bad++; $display("FAIL single_pre_fall tx=%b level=%0d exp tx=1 level=1", tx, level);
        end
        for (int i = 0; i < FLEN; i++) begin
            @(negedge clk);
            if (tx !== frame_bit(8'hA5, i / CPB) || busy !== 1'b1) begin
                if (errs == 0) $display("FAIL single_frame cyc=%0d tx=%b busy=%b exp tx=%b busy=1",
                                        i, tx, busy, frame_bit(8'hA5, i / CPB));
                errs++;
            end
        end
        total++; if (errs != 0) bad++;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || tx !== 1'b1) begin
            bad++; $display("FAIL single_end busy=%b tx=%b exp busy=0 tx=1", busy, tx);
        end
    endtask

    task automatic test_back_to_back;
        logic rec[$];
        int   acc_cyc[6];
        int   n = 0;
        int   errs = 0;
        logic acc;
        bit   lvl_checked = 0;
        bit   done = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (n >= 1) rec.push_back(tx);
            if (n == 5 && !lvl_checked) begin
                lvl_checked = 1;
                total++;
                if (level !== LW'(4) || ready !== 1'b0) begin
                    bad++; $display("FAIL b2b_full level=%0d ready=%b exp level=4 ready=0", level, ready);
                end
            end
            if (n >= 6 && rec.size() >= 2 + 6 * FLEN) begin
                done = 1;
                break;
            end
            acc = 1'b0;
            if (n < 6) begin
                valid = 1'b1; data = 8'(n + 1); acc = ready;
            end else begin
                valid = 1'b0;
            end
            @(posedge clk);
            if (acc) begin acc_cyc[n] = cyc; n++; end
        end
        valid = 1'b0;
        total++;
        if (!done) begin
            bad++; $display("FAIL b2b_timeout accepted=%0d exp=6", n);
        end else begin
            for (int k = 0; k < 6; k++) begin
                int exp_off;
                exp_off = (k < 5) ? k : FLEN + 2;
                total++;
                if (acc_cyc[k] - acc_cyc[0] != exp_off) begin
                    bad++; $display("FAIL b2b_accept byte=%0d offset=%0d exp=%0d", k, acc_cyc[k] - acc_cyc[0], exp_off);
                end
            end
            if (rec[0] !== 1'b1) errs++;
            for (int k = 0; k < 6 * FLEN; k++) begin
                logic e;
                e = frame_bit(8'((k / FLEN) + 1), (k % FLEN) / CPB);
                if (rec[k+1] !== e) begin
                    if (errs == 0) $display("FAIL b2b_stream cyc=%0d tx=%b exp=%b", k, rec[k+1], e);
                    errs++;
                end
            end
            if (rec[1 + 6 * FLEN] !== 1'b1) errs++;
            total++; if (errs != 0) begin bad++; $display("FAIL b2b_stream_errors count=%0d exp=0", errs); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle busy=%b exp=0", busy); end
        end
    endtask

`ifdef UART_HOST_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0] pv[2];
        logic       pp[2];
        pv[0] = 8'h07; pp[0] = 1'b1;
        pv[1] = 8'h03; pp[1] = 1'b0;
        for (int t = 0; t < 2; t++) begin
            int errs = 0;
            @(negedge clk);
            data = pv[t]; valid = 1'b1;
            @(posedge clk);
            #1 valid = 1'b0;
            @(negedge clk);
            for (int i = 0; i < FLEN; i++) begin
                @(negedge clk);
                if (tx !== frame_bit(pv[t], i / CPB)) begin
                    if (errs == 0) $display("FAIL parity_frame byte=%h cyc=%0d tx=%b", pv[t], i, tx);
                    errs++;
                end
                if (i / CPB == 9) begin
                    total++;
                    if (tx !== pp[t]) begin
                        bad++; $display("FAIL parity_bit byte=%h got=%b exp=%b", pv[t], tx, pp[t]);
                    end
                end
            end
            total++; if (errs != 0) bad++;
            @(negedge clk);
            total++;
            if (busy !== 1'b0) begin bad++; $display("FAIL parity_len byte=%h busy=%b exp=0", pv[t], busy); end
        end
    endtask
`endif

    task automatic test_random;
        logic [7:0] bytes[6];
        logic       rec[$];
        int         n = 0;
        int         gap;
        int         p = 0;
        logic       acc;
        bit         done = 0;
        foreach (bytes[i]) bytes[i] = 8'($urandom);
        gap = $urandom_range(0, 20);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rec.push_back(tx);
            if (n == 6 && !busy) begin done = 1; break; end
            acc = 1'b0;
            valid = 1'b0;
            if (n < 6) begin
                if (gap > 0) gap--;
                else begin valid = 1'b1; data = bytes[n]; acc = ready; end
            end
            @(posedge clk);
            if (acc) begin n++; gap = $urandom_range(0, 20); end
        end
        valid = 1'b0;
        total++;
        if (!done) begin bad++; $display("FAIL random_timeout sent=%0d exp=6", n); end
        for (int j = 0; j < 6; j++) begin
            int errs = 0;
            while (p < rec.size() && rec[p] === 1'b1) p++;
            if (p + FLEN > rec.size()) begin
                errs = 1;
            end else begin
                for (int k = 0; k < FLEN; k++)
                    if (rec[p+k] !== frame_bit(bytes[j], k / CPB)) errs++;
                p += FLEN;
            end
            total++;
            if (errs != 0) begin
                bad++; $display("FAIL random_frame idx=%0d byte=%h bit_errors=%0d exp=0", j, bytes[j], errs);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] b[3];
        int         n = 0;
        int         errs = 0;
        logic       acc;
        foreach (b[i]) b[i] = 8'($urandom);
        for (int cyc = 0; cyc < 50 && n < 3; cyc++) begin
            @(negedge clk);
            valid = 1'b1; data = b[n]; acc = ready;
            @(posedge clk);
            if (acc) n++;
        end
        #1 valid = 1'b0;
        repeat (4 * CPB) @(posedge clk);
        @(negedge clk);
        total++;
        if (tx !== b[0][3] || level !== LW'(2) || busy !== 1'b1) begin
            bad++; $display("FAIL rstmid_pre tx=%b level=%0d busy=%b exp tx=%b level=2 busy=1", tx, level, busy, b[0][3]);
        end
        rst = 1'b1;
        #1;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx got=%b exp=1", tx); end
        total++; if (level !== '0) begin bad++; $display("FAIL rstmid_level got=%0d exp=0", level); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2 * FLEN; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL rstmid_flushed errors=%0d exp=0", errs); end
        errs = 0;
        @(negedge clk);
        data = 8'h5A; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < FLEN; i++) begin
            @(negedge clk);
            if (tx !== frame_bit(8'h5A, i / CPB)) begin
                if (errs == 0) $display("FAIL rstmid_5a cyc=%0d tx=%b exp=%b", i, tx, frame_bit(8'h5A, i / CPB));
                errs++;
            end
        end
        total++; if (errs != 0) bad++;
        @(negedge clk);
    endtask

    task automatic test_loopback;
        logic [7:0] msg[3];
        msg[0] = 8'h4F; msg[1] = 8'h4B; msg[2] = 8'h0A;
        fork
            begin
                int n = 0;
                logic acc;
                for (int cyc = 0; cyc < 100 && n < 3; cyc++) begin
                    @(negedge clk);
                    lb_valid = 1'b1; lb_data = msg[n]; acc = lb_ready;
                    @(posedge clk);
                    if (acc) n++;
                end
                #1 lb_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 3; j++) begin
                    logic [7:0] got = '0;
                    bit found = 0;
                    bit framing = 1;
                    for (int t = 0; t < 20000; t++) begin
                        if (lb_tx === 1'b0) begin found = 1; break; end
                        #1;
                    end
                    total++;
                    if (!found) begin
                        bad++; $display("FAIL loopback_timeout byte=%0d", j);
                        break;
                    end
                    #340.0;
                    if (lb_tx !== 1'b0) framing = 0;
                    for (int k = 0; k < 8; k++) begin
                        #680.0;
                        got[k] = lb_tx;
                    end
`ifdef UART_HOST_TX_PARITY_EN
                    #680.0;
                    if (lb_tx !== ^got) framing = 0;
`endif
                    #680.0;
                    if (lb_tx !== 1'b1) framing = 0;
                    if (got !== msg[j] || !framing) begin
                        bad++; $display("FAIL loopback_byte idx=%0d got=%h exp=%h framing_ok=%0d", j, got, msg[j], framing);
                    end
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
`ifdef UART_HOST_TX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_reset_mid();
        test_loopback();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
